serial_exec_ctrl: RTL and testbench
===================================

SERIAL_EXEC_CTRL -- requirements
Module: serial_exec_ctrl

Interface
REQ-001 The block SHALL have one parameter: REG_WIDTH, default 8, meaning the register bit width and the number of serial shift cycles per instruction.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port instr_valid, input, 1 bit: the instruction source has a word on instr.
REQ-005 The block SHALL have port instr, input, 12 bits: the instruction word from the source.
REQ-006 The block SHALL have port instr_ready, output, 1 bit: the controller accepts instr this cycle.
REQ-007 The block SHALL have port stall, input, 1 bit: freezes serial shifting while high.
REQ-008 The block SHALL have port instr_q, output, 12 bits: the latched instruction, driven to the register file and ALU.
REQ-009 The block SHALL have port alu_op, output, 3 bits: instr_q[10:8].
REQ-010 The block SHALL have port alu_start, output, 1 bit: one-cycle pulse that clears the ALU carry and accumulator.
REQ-011 The block SHALL have port reg_shift_en, output, 1 bit: advances the register-file bit index by one.
REQ-012 The block SHALL have port reg_store_en, output, 1 bit: parallel write-back strobe to the register file.
REQ-013 The block SHALL have port bit_cnt, output, 3 bits: current serial bit position.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at instruction completion.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and STORE.
REQ-017 In IDLE, instr_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 In IDLE with instr_valid=1, the controller SHALL capture instr into instr_q and move to LOAD on the same edge.
REQ-019 instr_q SHALL stay stable from LOAD through STORE inclusive, and SHALL hold its value in IDLE.
REQ-020 In LOAD, alu_start SHALL be 1 for exactly one cycle, bit_cnt SHALL be 0, and the next state SHALL be SHIFT.
REQ-021 In SHIFT with stall=0, reg_shift_en SHALL be 1 and bit_cnt SHALL increment by 1 on each edge.
REQ-022 In SHIFT with stall=1, reg_shift_en SHALL be 0 and bit_cnt SHALL hold.
REQ-023 The shift-enable behaviour of REQ-021 and REQ-022 SHALL be a combinational function of stall.
REQ-024 On a non-stalled SHIFT cycle with bit_cnt=REG_WIDTH-1, bit_cnt SHALL wrap to 0 and the next state SHALL be STORE.
REQ-025 reg_shift_en SHALL be asserted exactly REG_WIDTH times per instruction, so a downstream modulo-REG_WIDTH bit index returns to 0.
REQ-026 In STORE, reg_store_en SHALL be 1 for one cycle unless instr_q[3]=1 (write-back inhibit), in which case it SHALL be 0.
REQ-027 In STORE, done SHALL be 1 for one cycle, and the next state SHALL be IDLE.
REQ-028 reg_shift_en and reg_store_en SHALL never be 1 in the same cycle.
REQ-029 alu_start and reg_shift_en SHALL never be 1 in the same cycle.
REQ-030 Minimum instruction period SHALL be REG_WIDTH+3 cycles (IDLE, LOAD, REG_WIDTH x SHIFT, STORE), plus one cycle per stalled SHIFT cycle.
REQ-031 There SHALL be no back-to-back acceptance: instr_valid held high during STORE SHALL be accepted only in the following IDLE cycle.
REQ-032 stall SHALL be ignored in IDLE, LOAD and STORE.
REQ-033 instr_valid SHALL be ignored outside IDLE.
REQ-034 alu_op SHALL be combinational from instr_q; all other outputs SHALL be decoded from the registered state and stall only, with no combinational path from instr_valid or instr.

Reset
REQ-035 When rstn=0, at any time and independent of clk, the state SHALL be IDLE, with bit_cnt=0, instr_q=0, busy=0, done=0, alu_start=0, reg_shift_en=0 and reg_store_en=0.
REQ-036 instr_ready SHALL be 1 after reset release.
REQ-037 A reset mid-SHIFT SHALL abandon the instruction, with no store and no done pulse.
REQ-038 The system SHALL hold rstn low across at least one rising clk edge so that synchronously reset downstream bit indices also clear.
REQ-039 The first instruction SHALL be accepted no earlier than the first rising edge after rstn deasserts.

Verification
REQ-040 Basic: instr=12'h123 with valid in IDLE -> alu_start at cycle 1, reg_shift_en high for cycles 2-9 with bit_cnt 0..7, reg_store_en and done at cycle 10, instr_ready at cycle 11.
REQ-041 Inhibit: instr=12'h008 -> identical timing, with reg_store_en 0 throughout and done 1 at cycle 10.
REQ-042 Stall: stall high for 3 cycles while bit_cnt=4 -> bit_cnt holds at 4, reg_shift_en 0 for those 3 cycles, exactly 8 shift pulses total, done at cycle 13.
REQ-043 Held valid: instr_valid continuously high with two words -> the second word is captured only in IDLE, and instructions complete 11 cycles apart.
REQ-044 Reset mid-op: rstn low at bit_cnt=5 (between edges) -> all outputs 0 and busy 0 immediately, no reg_store_en, and after release the next instruction runs with full 11-cycle timing.
REQ-045 Invariants: in every cycle, reg_shift_en and reg_store_en are never both 1, and the shift count between alu_start and done is always 8.

Source files
------------

// File: rtl/serial_exec_ctrl.sv
// Serial instruction sequencer: LOAD, REG_WIDTH shift cycles, STORE.
// Outputs decode from registered state and stall only.
module serial_exec_ctrl #(
  parameter int REG_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_valid,
  input  logic [11:0] instr,
  output logic        instr_ready,
  input  logic        stall,
  output logic [11:0] instr_q,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        reg_shift_en,
  output logic        reg_store_en,
  output logic [2:0]  bit_cnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE
  } state_e;

  localparam logic [2:0] LAST = 3'(REG_WIDTH - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] instr_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // stall freezes both the index and the phase
        if (!stall) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = STORE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      STORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign alu_start    = (state_q == LOAD);
  assign reg_shift_en = (state_q == SHIFT) && !stall;
  // instr_q[3] inhibits write-back
  assign reg_store_en = (state_q == STORE) && !instr_q[3];
  assign done         = (state_q == STORE);
  assign bit_cnt      = cnt_q;
  assign alu_op       = instr_q[10:8];

endmodule

// File: tb/tb_serial_exec_ctrl.sv
// Bench for serial_exec_ctrl: phase model checked every cycle,
// plus directed scenarios with literal timing expectations.
module tb_serial_exec_ctrl;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        stall = 1'b0;
  logic        instr_ready;
  logic [11:0] instr_q;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        reg_shift_en;
  logic        reg_store_en;
  logic [2:0]  bit_cnt;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  serial_exec_ctrl #(.REG_WIDTH(W)) dut (
    .clk(clk),
    .rstn(rstn),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_ready(instr_ready),
    .stall(stall),
    .instr_q(instr_q),
    .alu_op(alu_op),
    .alu_start(alu_start),
    .reg_shift_en(reg_shift_en),
    .reg_store_en(reg_store_en),
    .bit_cnt(bit_cnt),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an instruction is an ALU-start cycle, W shifts, then one store cycle.
  bit        m_active = 0;
  bit        m_started = 0;
  int        m_shifts = 0;
  logic [11:0] m_instr = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active  <= 0;
      m_started <= 0;
      m_shifts  <= 0;
      m_instr   <= '0;
    end else if (!m_active) begin
      if (instr_valid) begin
        m_active  <= 1;
        m_started <= 0;
        m_shifts  <= 0;
        m_instr   <= instr;
      end
    end else if (!m_started) begin
      m_started <= 1;
    end else if (m_shifts < W) begin
      if (!stall) m_shifts <= m_shifts + 1;
    end else begin
      m_active <= 0;
    end
  end

  wire m_load  = m_active && !m_started;
  wire m_shph  = m_active && m_started && (m_shifts < W);
  wire m_store = m_active && m_started && (m_shifts == W);

  int pulses = 0;
  int store_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    chk("instr_ready", int'(instr_ready), int'(!m_active));
    chk("busy", int'(busy), int'(m_active));
    chk("alu_start", int'(alu_start), int'(m_load));
    chk("reg_shift_en", int'(reg_shift_en), int'(m_shph && !stall));
    chk("reg_store_en", int'(reg_store_en),
        int'(m_store && !m_instr[3]));
    chk("done", int'(done), int'(m_store));
    chk("bit_cnt", int'(bit_cnt), m_shph ? (m_shifts % 8) : 0);
    chk("instr_q", int'(instr_q), int'(m_instr));
    chk("alu_op", int'(alu_op), int'(m_instr[10:8]));
    if (reg_shift_en && reg_store_en)
      chk("shift_store_excl", 1, 0);
    if (alu_start) pulses <= 0;
    else if (reg_shift_en) pulses <= pulses + 1;
    if (done) chk("shifts_per_instr", pulses, W);
    if (reg_store_en) store_cnt <= store_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // mode 0: no stall; 1: stall st_len cycles at bit_cnt 4;
  // 2: stall high only in IDLE/LOAD/STORE cycles (must be ignored)
  task automatic run(input logic [11:0] w0, input logic [11:0] w1,
                     input int nw, input int mode, input int st_len,
                     output int d0, output int d1);
    int c;
    int nacc;
    int nd;
    int left;
    c = 0; nacc = 0; nd = 0; left = st_len;
    d0 = -1; d1 = -1;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = w0;
    stall = (mode == 2);
    while (c < 60) begin
      @(negedge clk);
      if (done) begin
        if (nd == 0) d0 = c; else d1 = c;
        nd++;
      end
      if (instr_ready && instr_valid) nacc++;
      @(posedge clk); #1;
      c++;
      if (nacc >= nw) instr_valid = 1'b0;
      else if (nacc == 1) instr = w1;
      if (mode == 1) begin
        if (left > 0 && busy && !alu_start && bit_cnt == 3'd4) begin
          stall = 1'b1;
          left--;
        end else stall = 1'b0;
      end else if (mode == 2) begin
        stall = (c == 1 || c == 10);
      end
      if (nd == nw) break;
    end
    stall = 1'b0;
    instr_valid = 1'b0;
    if (nd != nw) chk("run_timeout", nd, nw);
  endtask

  int d0, d1, s0, ds0, p0;

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_instr_q", int'(instr_q), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    run(12'h123, 12'h000, 1, 0, 0, d0, d1);
    chk("basic_done_cycle", d0, 10);
    chk("basic_store_cnt", store_cnt, 1);
    chk("basic_instr_q", int'(instr_q), 'h123);
    chk("basic_ready_after", int'(instr_ready), 1);

    s0 = store_cnt;
    run(12'h008, 12'h000, 1, 0, 0, d0, d1);
    chk("inhibit_done_cycle", d0, 10);
    chk("inhibit_no_store", store_cnt, s0);

    p0 = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (reg_shift_en) p0++;
        end
      end
      run(12'h5A1, 12'h000, 1, 1, 3, d0, d1);
    join
    chk("stall_done_cycle", d0, 13);
    chk("stall_shift_pulses", p0, 8);

    run(12'h270, 12'h000, 1, 2, 0, d0, d1);
    chk("stall_ignored_done", d0, 10);

    run(12'h6A4, 12'h3F0, 2, 0, 0, d0, d1);
    chk("held_first_done", d0, 10);
    chk("held_second_done", d1, 21);
    chk("held_second_instr_q", int'(instr_q), 'h3F0);

    s0 = store_cnt;
    ds0 = done_cnt;
    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = 12'h155;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
      if (bit_cnt == 3'd5) break;
    end
    chk("reset_reached_cnt5", int'(bit_cnt), 5);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_shift", int'(reg_shift_en), 0);
    chk("midrst_bitcnt", int'(bit_cnt), 0);
    chk("midrst_instr_q", int'(instr_q), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_store", int'(reg_store_en), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("midrst_no_store", store_cnt, s0);
    chk("midrst_no_done", done_cnt, ds0);
    run(12'h123, 12'h000, 1, 0, 0, d0, d1);
    chk("post_reset_done", d0, 10);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
